// File: rtl/ball_engine.sv
// Ball engine for a COLS x ROWS pong matrix: ball motion, wall and paddle bounces,
// speed-up, miss detection, scoring and the serve/point/game-over sequence.
module ball_engine #(
    parameter int COLS         = 8,
    parameter int ROWS         = 8,
    parameter int PAD_W        = 3,
    parameter int START_PERIOD = 4,
    parameter int SPEEDUP_HITS = 4,
    parameter int SERVE_WAIT   = 2,
    parameter int WIN_SCORE    = 5,
    parameter int SCORE_W      = 4,
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step,
    input  logic [XW-1:0]      padA,
    input  logic [XW-1:0]      padB,
    output logic [XW-1:0]      ballX,
    output logic [YW-1:0]      ballY,
    output logic               dirX,
    output logic               dirY,
    output logic               playing,
    output logic               missA,
    output logic               missB,
    output logic [SCORE_W-1:0] scoreA,
    output logic [SCORE_W-1:0] scoreB,
    output logic               gameOver
);

    localparam int PW = $clog2(START_PERIOD + 1);
    localparam int HW = $clog2(SPEEDUP_HITS + 1);
    localparam int WW = $clog2(SERVE_WAIT + 2);

    localparam logic [XW-1:0]        X_MID     = XW'(COLS / 2);
    localparam logic [YW-1:0]        Y_MID     = YW'(ROWS / 2);
    localparam logic [XW-1:0]        X_MAX     = XW'(COLS - 1);
    localparam logic signed [XW:0]   XMAX_S    = $signed((XW + 1)'(COLS - 1));
    localparam logic signed [XW:0]   ONE_X     = $signed((XW + 1)'(1));
    localparam logic signed [XW:0]   NEG_X     = $signed({(XW + 1){1'b1}});
    localparam logic signed [YW:0]   ONE_Y     = $signed((YW + 1)'(1));
    localparam logic signed [YW:0]   NEG_Y     = $signed({(YW + 1){1'b1}});
    localparam logic signed [YW:0]   YLAST_S   = $signed((YW + 1)'(ROWS - 1));
    localparam logic signed [XW+1:0] H_S       = $signed((XW + 2)'((PAD_W - 1) / 2));
    localparam logic [PW-1:0]        P_START   = PW'(START_PERIOD);
    localparam logic [PW-1:0]        P_ONE     = PW'(1);
    localparam logic [HW-1:0]        HIT_LAST  = HW'(SPEEDUP_HITS - 1);
    localparam logic [WW-1:0]        WAIT_LAST = WW'((SERVE_WAIT > 0) ? SERVE_WAIT - 1 : 0);
    localparam logic [SCORE_W-1:0]   WIN_S     = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0]   S_MAX     = '1;

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;
    state_t state, stateNext;

    logic [PW-1:0] period, stepCnt;
    logic [HW-1:0] hitCnt;
    logic [WW-1:0] waitCnt;

    logic signed [XW:0]   nxRaw, nxWall;
    logic signed [YW:0]   nyRaw;
    logic signed [XW+1:0] nxS, cS;
    logic [XW-1:0]        padAc, padBc, padC;
    logic wallHit, dirXw, atA, atB, inSpan, hitNow, missNow, advance;
    logic serveEntry, newGame;

    // Next-position evaluation; the span test runs on unclipped bounds because the
    // post-wall column is always inside the matrix, so clipping cannot change the result.
    always_comb begin
        padAc   = (padA > X_MAX) ? X_MAX : padA;
        padBc   = (padB > X_MAX) ? X_MAX : padB;
        nxRaw   = $signed({1'b0, ballX}) + (dirX ? ONE_X : NEG_X);
        wallHit = nxRaw[XW] || (nxRaw > XMAX_S);
        dirXw   = wallHit ? ~dirX : dirX;
        nxWall  = wallHit ? ($signed({1'b0, ballX}) - (dirX ? ONE_X : NEG_X)) : nxRaw;
        nyRaw   = $signed({1'b0, ballY}) + (dirY ? ONE_Y : NEG_Y);
        atA     = (nyRaw == '0);
        atB     = (nyRaw == YLAST_S);
        padC    = atA ? padAc : padBc;
        cS      = $signed({2'b00, padC});
        nxS     = $signed({nxWall[XW], nxWall});
        inSpan  = (nxS >= cS - H_S) && (nxS <= cS + H_S);
        hitNow  = (atA || atB) && inSpan;
        missNow = (atA || atB) && !inSpan;
        advance = (state == PLAY) && step && (stepCnt == period - P_ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, OVER: if (start) stateNext = SERVE;
            SERVE:      if (step && waitCnt == WAIT_LAST) stateNext = PLAY;
            PLAY:       if (advance && missNow) stateNext = POINT;
            POINT:      if (step) stateNext = (scoreA == WIN_S || scoreB == WIN_S) ? OVER : SERVE;
            default:    stateNext = IDLE;
        endcase
    end

    always_comb begin
        playing  = (state == SERVE) || (state == PLAY) || (state == POINT);
        gameOver = (state == OVER);
    end

    assign serveEntry = (state != SERVE) && (stateNext == SERVE);
    assign newGame    = (state == IDLE) || (state == OVER);

    always_ff @(posedge clk) begin
        if (rst) begin
            ballX   <= X_MID;
            ballY   <= Y_MID;
            dirX    <= 1'b1;
            dirY    <= 1'b1;
            period  <= P_START;
            hitCnt  <= '0;
            stepCnt <= '0;
            waitCnt <= '0;
            scoreA  <= '0;
            scoreB  <= '0;
            missA   <= 1'b0;
            missB   <= 1'b0;
        end else begin
            missA <= 1'b0;
            missB <= 1'b0;
            if (serveEntry) begin
                ballX   <= X_MID;
                ballY   <= Y_MID;
                dirX    <= 1'b1;
                // After a point the serve heads towards whoever missed: A's row is 0.
                dirY    <= newGame | (ballY != '0);
                period  <= P_START;
                hitCnt  <= '0;
                stepCnt <= '0;
                waitCnt <= '0;
                if (newGame) begin
                    scoreA <= '0;
                    scoreB <= '0;
                end
            end else if (state == SERVE && step) begin
                waitCnt <= waitCnt + 1'b1;
            end else if (state == PLAY && step) begin
                stepCnt <= advance ? '0 : stepCnt + 1'b1;
                if (advance) begin
                    ballX <= nxWall[XW-1:0];
                    if (hitNow) begin
                        dirY <= ~dirY;
                        if (nxS == cS - H_S)      dirX <= 1'b0;
                        else if (nxS == cS + H_S) dirX <= 1'b1;
                        else                      dirX <= dirXw;
                        if (hitCnt == HIT_LAST) begin
                            hitCnt <= '0;
                            if (period > P_ONE) period <= period - P_ONE;
                        end else begin
                            hitCnt <= hitCnt + 1'b1;
                        end
                    end else begin
                        ballY <= nyRaw[YW-1:0];
                        dirX  <= dirXw;
                        if (missNow && atA) begin
                            missA <= 1'b1;
                            if (scoreB != S_MAX) scoreB <= scoreB + 1'b1;
                        end else if (missNow) begin
                            missB <= 1'b1;
                            if (scoreA != S_MAX) scoreA <= scoreA + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ball_engine.sv
// Scoreboard bench for ball_engine: two instances (fast serve/short game, and slow
// period with quick speed-up) driven through serve, bounce, miss, speed-up and reset scenarios.
`timescale 1ns/1ps
module tb_ball_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start1, step1, start2, step2;
    logic [2:0] padA1, padB1, padA2, padB2;
    logic [2:0] ballX1, ballY1, ballX2, ballY2;
    logic       dirX1, dirY1, dirX2, dirY2;
    logic       playing1, missA1, missB1, gameOver1;
    logic       playing2, missA2, missB2, gameOver2;
    logic [3:0] scoreA1, scoreB1, scoreA2, scoreB2;

    ball_engine #(.COLS(8), .ROWS(8), .PAD_W(3), .START_PERIOD(1), .SPEEDUP_HITS(4),
                  .SERVE_WAIT(2), .WIN_SCORE(2), .SCORE_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .step(step1), .padA(padA1), .padB(padB1),
        .ballX(ballX1), .ballY(ballY1), .dirX(dirX1), .dirY(dirY1), .playing(playing1),
        .missA(missA1), .missB(missB1), .scoreA(scoreA1), .scoreB(scoreB1), .gameOver(gameOver1));

    ball_engine #(.COLS(8), .ROWS(8), .PAD_W(3), .START_PERIOD(3), .SPEEDUP_HITS(2),
                  .SERVE_WAIT(2), .WIN_SCORE(5), .SCORE_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .step(step2), .padA(padA2), .padB(padB2),
        .ballX(ballX2), .ballY(ballY2), .dirX(dirX2), .dirY(dirY2), .playing(playing2),
        .missA(missA2), .missB(missB2), .scoreA(scoreA2), .scoreB(scoreB2), .gameOver(gameOver2));

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic       dx;
        logic       dy;
        logic [3:0] sa;
        logic [3:0] sb;
        logic       pl;
        logic       go;
        logic       ma;
        logic       mb;
    } snap_t;

    typedef struct packed {
        logic  rs;
        logic  st;
        logic  sp;
        snap_t s;
    } ent_t;

    typedef struct {
        int x;
        int y;
        int n;
    } adv_t;

    ent_t       q1[$];
    adv_t       qa[$];
    logic [2:0] qf[$];
    int total = 0;
    int bad   = 0;

    function automatic snap_t mk(input int x, y, dx, dy, sa, sb, pl, go, ma, mb);
        snap_t s;
        s.x  = 3'(x);  s.y  = 3'(y);  s.dx = 1'(dx); s.dy = 1'(dy);
        s.sa = 4'(sa); s.sb = 4'(sb); s.pl = 1'(pl); s.go = 1'(go);
        s.ma = 1'(ma); s.mb = 1'(mb);
        return s;
    endfunction

    function automatic ent_t en(input logic rs, st, sp, input snap_t s);
        ent_t e;
        e.rs = rs; e.st = st; e.sp = sp; e.s = s;
        return e;
    endfunction

    function automatic snap_t obs1();
        snap_t s;
        s.x  = ballX1;  s.y  = ballY1;  s.dx = dirX1;    s.dy = dirY1;
        s.sa = scoreA1; s.sb = scoreB1; s.pl = playing1; s.go = gameOver1;
        s.ma = missA1;  s.mb = missB1;
        return s;
    endfunction

    function automatic snap_t obs2();
        snap_t s;
        s.x  = ballX2;  s.y  = ballY2;  s.dx = dirX2;    s.dy = dirY2;
        s.sa = scoreA2; s.sb = scoreB2; s.pl = playing2; s.go = gameOver2;
        s.ma = missA2;  s.mb = missB2;
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("pos=(%0d,%0d) dir=%0d%0d score=%0d:%0d playing=%0d over=%0d miss=%0d%0d",
                         s.x, s.y, s.dx, s.dy, s.sa, s.sb, s.pl, s.go, s.ma, s.mb);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        snap_t e, g1, g2;
        rst = 1'b1; start1 = 1'b1; step1 = 1'b1; start2 = 1'b1; step2 = 1'b1;
        e = mk(4, 4, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0; start1 = 1'b0; step1 = 1'b0; start2 = 1'b0; step2 = 1'b0;
        g1 = obs1();
        g2 = obs2();
        total++;
        if (g1 !== e) begin
            bad++;
            $display("FAIL reset_dut1 got %s want %s", fmt(g1), fmt(e));
        end
        total++;
        if (g2 !== e) begin
            bad++;
            $display("FAIL reset_dut2 got %s want %s", fmt(g2), fmt(e));
        end
    endtask

    task automatic test_hit_wall();
        ent_t  e;
        snap_t g;
        int    n = 0;
        padA1 = 3'd6; padB1 = 3'd6;
        q1.push_back(en(0, 1, 0, mk(4, 4, 1, 1, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(4, 4, 1, 1, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(4, 4, 1, 1, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(5, 5, 1, 1, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(6, 6, 1, 1, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(7, 6, 1, 0, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(6, 5, 0, 0, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 1, 0, mk(6, 5, 0, 0, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(5, 4, 0, 0, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(4, 3, 0, 0, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(3, 2, 0, 0, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(2, 1, 0, 0, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0)));
        q1.push_back(en(0, 0, 0, mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(4, 4, 1, 0, 0, 1, 1, 0, 0, 0)));
        while (q1.size() > 0) begin
            e = q1.pop_front();
            rst = e.rs; start1 = e.st; step1 = e.sp;
            tick();
            rst = 1'b0; start1 = 1'b0; step1 = 1'b0;
            g = obs1();
            total++;
            if (g !== e.s) begin
                bad++;
                $display("FAIL hit_wall[%0d] got %s want %s", n, fmt(g), fmt(e.s));
            end
            n++;
        end
    endtask

    task automatic test_mid_reset();
        ent_t  e;
        snap_t g;
        int    n = 0;
        q1.push_back(en(0, 0, 1, mk(4, 4, 1, 0, 0, 1, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(4, 4, 1, 0, 0, 1, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(5, 3, 1, 0, 0, 1, 1, 0, 0, 0)));
        q1.push_back(en(1, 1, 1, mk(4, 4, 1, 1, 0, 0, 0, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(4, 4, 1, 1, 0, 0, 0, 0, 0, 0)));
        while (q1.size() > 0) begin
            e = q1.pop_front();
            rst = e.rs; start1 = e.st; step1 = e.sp;
            tick();
            rst = 1'b0; start1 = 1'b0; step1 = 1'b0;
            g = obs1();
            total++;
            if (g !== e.s) begin
                bad++;
                $display("FAIL mid_reset[%0d] got %s want %s", n, fmt(g), fmt(e.s));
            end
            n++;
        end
    endtask

    task automatic test_miss_game_over();
        ent_t  e;
        snap_t g;
        int    n = 0;
        padA1 = 3'd4; padB1 = 3'd1;
        q1.push_back(en(0, 1, 0, mk(4, 4, 1, 1, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(4, 4, 1, 1, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(4, 4, 1, 1, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(5, 5, 1, 1, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(6, 6, 1, 1, 0, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(7, 7, 1, 1, 1, 0, 1, 0, 0, 1)));
        q1.push_back(en(0, 0, 0, mk(7, 7, 1, 1, 1, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(4, 4, 1, 1, 1, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(4, 4, 1, 1, 1, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(4, 4, 1, 1, 1, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(5, 5, 1, 1, 1, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(6, 6, 1, 1, 1, 0, 1, 0, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(7, 7, 1, 1, 2, 0, 1, 0, 0, 1)));
        q1.push_back(en(0, 0, 1, mk(7, 7, 1, 1, 2, 0, 0, 1, 0, 0)));
        q1.push_back(en(0, 0, 1, mk(7, 7, 1, 1, 2, 0, 0, 1, 0, 0)));
        q1.push_back(en(0, 1, 0, mk(4, 4, 1, 1, 0, 0, 1, 0, 0, 0)));
        while (q1.size() > 0) begin
            e = q1.pop_front();
            rst = e.rs; start1 = e.st; step1 = e.sp;
            tick();
            rst = 1'b0; start1 = 1'b0; step1 = 1'b0;
            g = obs1();
            total++;
            if (g !== e.s) begin
                bad++;
                $display("FAIL miss_game_over[%0d] got %s want %s", n, fmt(g), fmt(e.s));
            end
            n++;
        end
    endtask

    task automatic test_speedup();
        adv_t       e;
        logic [2:0] px, py;
        int         cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        padA2 = 3'd1; padB2 = 3'd7;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (2) begin
            step2 = 1'b1;
            tick();
            step2 = 1'b0;
        end
        total++;
        if ({ballX2, ballY2, playing2} !== {3'd4, 3'd4, 1'b1}) begin
            bad++;
            $display("FAIL speedup_serve got (%0d,%0d) playing=%0d want (4,4) playing=1",
                     ballX2, ballY2, playing2);
        end
        qa.push_back('{5, 5, 3}); qa.push_back('{6, 6, 3}); qa.push_back('{7, 6, 3});
        qa.push_back('{6, 5, 3}); qa.push_back('{5, 4, 3}); qa.push_back('{4, 3, 3});
        qa.push_back('{3, 2, 3}); qa.push_back('{2, 1, 3}); qa.push_back('{1, 1, 3});
        qa.push_back('{0, 2, 2}); qa.push_back('{1, 3, 2}); qa.push_back('{2, 4, 2});
        for (int k = 0; qa.size() > 0; k++) begin
            e   = qa.pop_front();
            px  = ballX2;
            py  = ballY2;
            cnt = 0;
            while ({ballX2, ballY2} === {px, py} && cnt < 8) begin
                step2 = 1'b1;
                tick();
                step2 = 1'b0;
                cnt++;
            end
            total++;
            if (ballX2 !== 3'(e.x) || ballY2 !== 3'(e.y) || cnt != e.n) begin
                bad++;
                $display("FAIL speedup_adv[%0d] got (%0d,%0d) after %0d steps want (%0d,%0d) after %0d",
                         k, ballX2, ballY2, cnt, e.x, e.y, e.n);
            end
        end
    endtask

    task automatic test_period_floor();
        logic [2:0] px, py, want, got;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (2) begin
            step1 = 1'b1;
            tick();
            step1 = 1'b0;
        end
        for (int k = 0; k < 40; k++) begin
            padA1 = ballX1;
            padB1 = ballX1;
            px = ballX1;
            py = ballY1;
            qf.push_back(3'b100);
            step1 = 1'b1;
            tick();
            step1 = 1'b0;
            got  = {({ballX1, ballY1} !== {px, py}), missA1, missB1};
            want = qf.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL period_floor[%0d] got moved/missA/missB=%b want %b at (%0d,%0d)",
                         k, got, want, ballX1, ballY1);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        start1 = 1'b0; step1 = 1'b0; padA1 = 3'd0; padB1 = 3'd0;
        start2 = 1'b0; step2 = 1'b0; padA2 = 3'd0; padB2 = 3'd0;
        tick();
        test_reset();
        test_hit_wall();
        test_mid_reset();
        test_miss_game_over();
        test_speedup();
        test_period_floor();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
